hls_fifo_responder: RTL
=======================

Name: hls_fifo_responder

Overview:
- Memory-side responder for the HLS FIFO bus protocol.
- Pops data-bus commands (address, data, mask, write, uncached, size, last) from seven ap_fifo streams and serves them from an on-chip word-addressed scratchpad.
- Pushes read responses (data, last) into two ap_fifo streams.
- Stands in for, or fronts, HLS kernel memory so the CPU-side FIFO path can be closed in RTL simulation and synthesis.

Parameters:
- DATA_WIDTH, 32, bus data width in bits; must be 32 (four mask bits).
- DATA_ADDR_WIDTH, 32, width of the word address carried in the address FIFO.
- MEM_DEPTH_LOG2, 10, log2 of scratchpad depth in words (default 1024 words).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_address_dout  in  DATA_ADDR_WIDTH  word address (already >>2)
- cmd_data_dout  in  DATA_WIDTH  write data
- cmd_mask_dout  in  4  byte enables
- cmd_write_dout  in  1  1=write, 0=read
- cmd_uncached_dout  in  1  ignored
- cmd_size_dout  in  3  ignored; mask governs
- cmd_last_dout  in  1  ignored
- cmd_<field>_empty_n  in  1  one per field above (7 ports); 1=FIFO has data
- cmd_<field>_read  out  1  one per field (7 ports); pop strobe
- rsp_data_din  out  DATA_WIDTH  read data
- rsp_data_full_n  in  1  1=space available
- rsp_data_write  out  1  push strobe
- rsp_last_din  out  1  always 1
- rsp_last_full_n  in  1  1=space available
- rsp_last_write  out  1  push strobe
- busy  out  1  state != IDLE
- addr_err  out  1  sticky out-of-range flag

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; all *_read and *_write outputs 0; rsp_data_din=0; busy=0; addr_err=0. Scratchpad contents are not reset.
- Reset mid-operation: a pending read response is discarded and the state returns to IDLE. A command already popped is not replayed.
- cmd_avail = AND of all seven empty_n inputs.
- All seven *_read strobes are identical and asserted only in IDLE while cmd_avail=1 and rst=0. A partial pop is never allowed.
- Address decode:
  - in_range when cmd_address_dout[DATA_ADDR_WIDTH-1:MEM_DEPTH_LOG2]==0.
  - Index = cmd_address_dout[MEM_DEPTH_LOG2-1:0].
- IDLE:
  - On pop with write=1: byte lanes where mask[i]=1 are written at the clock edge; other lanes keep their old value.
  - A write produces no response. The FSM stays in IDLE, so sustained throughput is 1 write per cycle.
  - Out-of-range write: the write is dropped and addr_err is set.
- IDLE, pop with write=0: a synchronous RAM read is issued and the FSM goes to RD.
- RD: the RAM output is captured into rsp_data_din. An out-of-range read captures 0 and sets addr_err. The FSM goes to RSP.
- RSP:
  - rsp_data_write = rsp_last_write = rsp_data_full_n & rsp_last_full_n & ~rst.
  - rsp_last_din=1.
  - The FSM returns to IDLE in the cycle the strobes fire and holds in RSP otherwise.
  - rsp_data_din stays stable while the FSM holds in RSP.
- Read latency: pop at cycle N gives the earliest response push at N+2. Peak read throughput is 1 per 3 cycles.
- Read-after-write: a write popped at N followed by a read popped at N+1 to the same word returns the new data. The write commits at the edge ending N, before the read issues.
- A mask of 0 on a write is a no-op store that still pops.
- addr_err clears only on rst.

Optional Feature:
- Macro: HLS_FIFO_RESPONDER_STATS_EN.
- With the macro defined:
  - Adds outputs stat_rd_cnt and stat_wr_cnt (each 32 bits).
  - stat_rd_cnt increments on each response push; stat_wr_cnt increments on each write pop, including dropped writes.
  - Both wrap from 0xFFFFFFFF to 0 and reset to 0.
- Without the macro: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package hls_bus_pkg holds:
  - DATA_WIDTH and MASK_WIDTH constants;
  - the responder state enum (IDLE, RD, RSP);
  - a function apply_mask(old, new, mask) returning the merged word.
- Sub-module hls_scratch_ram: single-port synchronous RAM with byte write enables, 1-cycle read latency, depth 2**MEM_DEPTH_LOG2.

Test Plan:
- Reset with all FIFOs non-empty -> no *_read asserted while rst=1; busy=0, addr_err=0.
- Write addr=0x4, data=0xDEADBEEF, mask=0xF; then read addr=0x4 -> one rsp push with data 0xDEADBEEF, last=1, exactly 2 cycles after the read pop.
- Write 0x11223344 mask=0xF, then 0xAABBCCDD mask=0x5 to addr 0x10; read 0x10 -> 0x11BB33DD.
- Read pending with rsp_data_full_n=0 for 5 cycles -> FSM holds in RSP, no pops, data stable; push fires in the cycle full_n returns to 1.
- Address-FIFO empty_n=0 while the others are 1 -> no pops. Read of addr 0x400 with MEM_DEPTH_LOG2=10 -> rsp data 0 and addr_err=1 sticky until rst.
- With stats enabled: 3 writes and 2 reads -> stat_wr_cnt=3, stat_rd_cnt=2. A counter preloaded to 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/hls_bus_pkg.sv
// Shared definitions for the HLS FIFO bus responder: bus widths, responder states
// and the byte-lane merge used by scratchpad writes.
package hls_bus_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RSP  = 2'd2
    } resp_state_t;

    function automatic logic [DATA_WIDTH-1:0] apply_mask(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [MASK_WIDTH-1:0] mask
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/hls_scratch_ram.sv
// Single-port word-addressed scratchpad with per-byte write enables and a
// registered (1-cycle) read port.
module hls_scratch_ram
    import hls_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [MASK_WIDTH-1:0] be,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= apply_mask(mem[addr], wdata, be);
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/hls_fifo_responder.sv
// Memory-side responder for the HLS FIFO bus: pops commands, serves them from a
// scratchpad, pushes read responses. Optional counters: HLS_FIFO_RESPONDER_STATS_EN.
module hls_fifo_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH_LOG2  = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_ADDR_WIDTH-1:0]       cmd_address_dout,
    input  logic                             cmd_address_empty_n,
    output logic                             cmd_address_read,
    input  logic [DATA_WIDTH-1:0]            cmd_data_dout,
    input  logic                             cmd_data_empty_n,
    output logic                             cmd_data_read,
    input  logic [hls_bus_pkg::MASK_WIDTH-1:0] cmd_mask_dout,
    input  logic                             cmd_mask_empty_n,
    output logic                             cmd_mask_read,
    input  logic                             cmd_write_dout,
    input  logic                             cmd_write_empty_n,
    output logic                             cmd_write_read,
    input  logic                             cmd_uncached_dout,
    input  logic                             cmd_uncached_empty_n,
    output logic                             cmd_uncached_read,
    input  logic [2:0]                       cmd_size_dout,
    input  logic                             cmd_size_empty_n,
    output logic                             cmd_size_read,
    input  logic                             cmd_last_dout,
    input  logic                             cmd_last_empty_n,
    output logic                             cmd_last_read,
    output logic [DATA_WIDTH-1:0]            rsp_data_din,
    input  logic                             rsp_data_full_n,
    output logic                             rsp_data_write,
    output logic                             rsp_last_din,
    input  logic                             rsp_last_full_n,
    output logic                             rsp_last_write,
    output logic                             busy,
    output logic                             addr_err,
    output logic [1:0]                       dbg_state
`ifdef HLS_FIFO_RESPONDER_STATS_EN
    ,
    output logic [31:0]                      stat_rd_cnt,
    output logic [31:0]                      stat_wr_cnt
`endif
);

    import hls_bus_pkg::*;

    resp_state_t               state, state_nxt;
    logic                      cmd_avail;
    logic                      pop;
    logic                      push;
    logic                      in_range;
    logic                      rd_in_range_q;
    logic [MEM_DEPTH_LOG2-1:0] idx;
    logic [DATA_WIDTH-1:0]     ram_rdata;
    logic [DATA_WIDTH-1:0]     rsp_data_q;
    logic                      unused_cmd_fields;

    // Uncached, size and last carry no meaning for a flat scratchpad; the mask governs.
    assign unused_cmd_fields = ^{cmd_uncached_dout, cmd_size_dout, cmd_last_dout};

    assign cmd_avail = &{cmd_address_empty_n, cmd_data_empty_n, cmd_mask_empty_n,
                         cmd_write_empty_n, cmd_uncached_empty_n, cmd_size_empty_n,
                         cmd_last_empty_n};

    // All seven streams pop together so command fields never drift apart.
    assign pop = (state == IDLE) && cmd_avail && !rst;

    assign cmd_address_read  = pop;
    assign cmd_data_read     = pop;
    assign cmd_mask_read     = pop;
    assign cmd_write_read    = pop;
    assign cmd_uncached_read = pop;
    assign cmd_size_read     = pop;
    assign cmd_last_read     = pop;

    assign in_range = (cmd_address_dout[DATA_ADDR_WIDTH-1:MEM_DEPTH_LOG2] == '0);
    assign idx      = cmd_address_dout[MEM_DEPTH_LOG2-1:0];

    assign push = (state == RSP) && rsp_data_full_n && rsp_last_full_n && !rst;

    hls_scratch_ram #(
        .ADDR_WIDTH (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (pop && cmd_write_dout && in_range),
        .be    (cmd_mask_dout),
        .re    (pop && !cmd_write_dout),
        .addr  (idx),
        .wdata (cmd_data_dout),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pop && !cmd_write_dout) state_nxt = RD;
            RD:   state_nxt = RSP;
            RSP:  if (push) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q    <= '0;
            rd_in_range_q <= 1'b0;
            addr_err      <= 1'b0;
        end else begin
            if (pop && !cmd_write_dout) begin
                rd_in_range_q <= in_range;
            end
            if (pop && cmd_write_dout && !in_range) begin
                addr_err <= 1'b1;
            end
            // Response word is frozen here and held for the whole RSP stall.
            if (state == RD) begin
                rsp_data_q <= rd_in_range_q ? ram_rdata : '0;
                if (!rd_in_range_q) begin
                    addr_err <= 1'b1;
                end
            end
        end
    end

    assign rsp_data_din   = rsp_data_q;
    assign rsp_data_write = push;
    assign rsp_last_write = push;
    assign rsp_last_din   = 1'b1;
    assign busy           = (state != IDLE);
    assign dbg_state      = state;

`ifdef HLS_FIFO_RESPONDER_STATS_EN
    logic [31:0] stat_rd_q;
    logic [31:0] stat_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            if (push) begin
                stat_rd_q <= stat_rd_q + 32'd1;
            end
            if (pop && cmd_write_dout) begin
                stat_wr_q <= stat_wr_q + 32'd1;
            end
        end
    end

    assign stat_rd_cnt = stat_rd_q;
    assign stat_wr_cnt = stat_wr_q;
`endif

endmodule
